// File: rtl/calc2_req_sched_if.sv
// Signal bundle of calc2_req_sched: four requester ports, the ALU issue/response ports,
// the drop counter and a per-port FSM state debug view.
interface calc2_req_sched_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
);
  logic [3:0]        req1_cmd_in,  req2_cmd_in,  req3_cmd_in,  req4_cmd_in;
  logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [TAG_W-1:0]  req1_tag_in,  req2_tag_in,  req3_tag_in,  req4_tag_in;
  logic              req1_busy,    req2_busy,    req3_busy,    req4_busy;
  logic [1:0]        out_resp1,    out_resp2,    out_resp3,    out_resp4;
  logic [DATA_W-1:0] out_data1,    out_data2,    out_data3,    out_data4;
  logic [TAG_W-1:0]  out_tag1,     out_tag2,     out_tag3,     out_tag4;
  // alu_valid/alu_ready: a transfer occurs on every rising edge where both are high;
  // once alu_valid rises, it and all alu_* fields hold unchanged until that transfer.
  logic              alu_valid, alu_ready;
  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_op1, alu_op2;
  logic [1:0]        alu_port;
  logic [TAG_W-1:0]  alu_tag;
  logic              alu_rsp_valid;
  logic [1:0]        alu_rsp_resp;
  logic [DATA_W-1:0] alu_rsp_data;
  logic [1:0]        alu_rsp_port;
  logic [TAG_W-1:0]  alu_rsp_tag;
  logic [7:0]        drop_cnt;
  logic [7:0]        dbg_state;

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
    output req1_busy, req2_busy, req3_busy, req4_busy,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4,
    output out_tag1, out_tag2, out_tag3, out_tag4,
    output alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag,
    input  alu_ready,
    input  alu_rsp_valid, alu_rsp_resp, alu_rsp_data, alu_rsp_port, alu_rsp_tag,
    output drop_cnt, dbg_state
  );

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in,
    input  req1_busy, req2_busy, req3_busy, req4_busy,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_tag1, out_tag2, out_tag3, out_tag4,
    input  alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag,
    output alu_ready,
    output alu_rsp_valid, alu_rsp_resp, alu_rsp_data, alu_rsp_port, alu_rsp_tag,
    input  drop_cnt, dbg_state
  );
endinterface

// File: rtl/calc2_req_sched.sv
// Four-port calc2 request scheduler: per-port command buffers, round-robin ALU issue,
// response routing. Define CALC2_SCHED_DROPCNT_EN to build the saturating drop counter.
module calc2_req_sched #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input logic          c_clk,
  input logic          reset_n,
  calc2_req_sched_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OP2 = 2'd1, ST_FULL = 2'd2} port_st_e;

  logic [3:0]        cmd_in  [4];
  logic [DATA_W-1:0] data_in [4];
  logic [TAG_W-1:0]  tag_in  [4];
  assign cmd_in[0]  = bus.req1_cmd_in;  assign cmd_in[1]  = bus.req2_cmd_in;
  assign cmd_in[2]  = bus.req3_cmd_in;  assign cmd_in[3]  = bus.req4_cmd_in;
  assign data_in[0] = bus.req1_data_in; assign data_in[1] = bus.req2_data_in;
  assign data_in[2] = bus.req3_data_in; assign data_in[3] = bus.req4_data_in;
  assign tag_in[0]  = bus.req1_tag_in;  assign tag_in[1]  = bus.req2_tag_in;
  assign tag_in[2]  = bus.req3_tag_in;  assign tag_in[3]  = bus.req4_tag_in;

  port_st_e          st_q [4], st_d [4];
  logic [3:0]        cmd_q [4];
  logic [DATA_W-1:0] op1_q [4], op2_q [4];
  logic [TAG_W-1:0]  tag_q [4];
  logic [3:0]        loc_sent_q, loc_fire, rsp_hit, elig, busy;
  logic [1:0]        ptr_q, ptr_d, grant_idx;
  logic              grant_vld, hs, issue_free;

  logic              alu_valid_q, alu_valid_d;
  logic [3:0]        alu_cmd_q, alu_cmd_d;
  logic [DATA_W-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [1:0]        alu_port_q, alu_port_d;
  logic [TAG_W-1:0]  alu_tag_q, alu_tag_d;

  logic [1:0]        resp_q [4], resp_d [4];
  logic [DATA_W-1:0] odata_q [4], odata_d [4];
  logic [TAG_W-1:0]  otag_q [4], otag_d [4];

  function automatic logic cmd_ok(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // The buffer sitting in the issue register is excluded so it cannot be granted twice.
  always_comb begin : port_fsm
    hs         = alu_valid_q && bus.alu_ready;
    issue_free = !alu_valid_q || bus.alu_ready;
    for (int i = 0; i < 4; i++) begin
      busy[i]     = (st_q[i] != ST_IDLE);
      rsp_hit[i]  = bus.alu_rsp_valid && (bus.alu_rsp_port == 2'(i));
      loc_fire[i] = (st_q[i] == ST_FULL) && !cmd_ok(cmd_q[i]) && !loc_sent_q[i] && !rsp_hit[i];
      elig[i]     = (st_q[i] == ST_FULL) && cmd_ok(cmd_q[i]) &&
                    !(alu_valid_q && (alu_port_q == 2'(i)));
      st_d[i]     = st_q[i];
      case (st_q[i])
        ST_IDLE: if (cmd_in[i] != 4'd0) st_d[i] = ST_OP2;
        ST_OP2:  st_d[i] = ST_FULL;
        ST_FULL: if ((hs && (alu_port_q == 2'(i))) || loc_sent_q[i]) st_d[i] = ST_IDLE;
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  always_comb begin : arbiter
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    for (int off = 0; off < 4; off++) begin
      if (!grant_vld && elig[ptr_q + 2'(off)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr_q + 2'(off);
      end
    end
    ptr_d       = ptr_q;
    alu_valid_d = alu_valid_q;
    alu_cmd_d   = alu_cmd_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_port_d  = alu_port_q;
    alu_tag_d   = alu_tag_q;
    if (issue_free) begin
      alu_valid_d = grant_vld;
      if (grant_vld) begin
        alu_cmd_d  = cmd_q[grant_idx];
        alu_op1_d  = op1_q[grant_idx];
        alu_op2_d  = op2_q[grant_idx];
        alu_port_d = grant_idx;
        alu_tag_d  = tag_q[grant_idx];
        ptr_d      = grant_idx + 2'd1;
      end
    end
  end

  // ALU responses take priority; a colliding local answer waits a cycle.
  always_comb begin : resp_route
    for (int i = 0; i < 4; i++) begin
      resp_d[i]  = 2'b00;
      odata_d[i] = odata_q[i];
      otag_d[i]  = otag_q[i];
      if (rsp_hit[i]) begin
        resp_d[i]  = bus.alu_rsp_resp;
        odata_d[i] = bus.alu_rsp_data;
        otag_d[i]  = bus.alu_rsp_tag;
      end else if (loc_fire[i]) begin
        resp_d[i]  = 2'b10;
        odata_d[i] = '0;
        otag_d[i]  = tag_q[i];
      end
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]    <= ST_IDLE;
        cmd_q[i]   <= '0;
        op1_q[i]   <= '0;
        op2_q[i]   <= '0;
        tag_q[i]   <= '0;
        resp_q[i]  <= '0;
        odata_q[i] <= '0;
        otag_q[i]  <= '0;
      end
      loc_sent_q  <= '0;
      ptr_q       <= '0;
      alu_valid_q <= 1'b0;
      alu_cmd_q   <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_port_q  <= '0;
      alu_tag_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]    <= st_d[i];
        resp_q[i]  <= resp_d[i];
        odata_q[i] <= odata_d[i];
        otag_q[i]  <= otag_d[i];
        if ((st_q[i] == ST_IDLE) && (cmd_in[i] != 4'd0)) begin
          cmd_q[i] <= cmd_in[i];
          op1_q[i] <= data_in[i];
          tag_q[i] <= tag_in[i];
        end
        if (st_q[i] == ST_OP2) op2_q[i] <= data_in[i];
      end
      loc_sent_q  <= loc_fire;
      ptr_q       <= ptr_d;
      alu_valid_q <= alu_valid_d;
      alu_cmd_q   <= alu_cmd_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_port_q  <= alu_port_d;
      alu_tag_q   <= alu_tag_d;
    end
  end

`ifdef CALC2_SCHED_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_sum;

  // A drop is a new command while the buffer is FULL; the operand-2 beat ignores cmd.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < 4; i++) begin
      if ((st_q[i] == ST_FULL) && (cmd_in[i] != 4'd0)) drop_sum = drop_sum + 9'd1;
    end
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'h00;
`endif

  assign bus.req1_busy = busy[0];  assign bus.req2_busy = busy[1];
  assign bus.req3_busy = busy[2];  assign bus.req4_busy = busy[3];
  assign bus.out_resp1 = resp_q[0];  assign bus.out_resp2 = resp_q[1];
  assign bus.out_resp3 = resp_q[2];  assign bus.out_resp4 = resp_q[3];
  assign bus.out_data1 = odata_q[0]; assign bus.out_data2 = odata_q[1];
  assign bus.out_data3 = odata_q[2]; assign bus.out_data4 = odata_q[3];
  assign bus.out_tag1  = otag_q[0];  assign bus.out_tag2  = otag_q[1];
  assign bus.out_tag3  = otag_q[2];  assign bus.out_tag4  = otag_q[3];
  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_cmd   = alu_cmd_q;
  assign bus.alu_op1   = alu_op1_q;
  assign bus.alu_op2   = alu_op2_q;
  assign bus.alu_port  = alu_port_q;
  assign bus.alu_tag   = alu_tag_q;
  assign bus.dbg_state = {st_q[3], st_q[2], st_q[1], st_q[0]};
endmodule

// File: tb/tb_calc2_req_sched.sv
// Directed self-checking bench for calc2_req_sched; inputs change and outputs are
// sampled on the falling edge of c_clk.
module tb_calc2_req_sched;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 2;
  localparam int OB     = DATA_W + TAG_W + 2;
  localparam int AB     = 1 + 4 + 2 * DATA_W + 2 + TAG_W;
`ifdef CALC2_SCHED_DROPCNT_EN
  localparam logic [7:0] DROP_ONE = 8'h01;
  localparam logic [7:0] DROP_SAT = 8'hFF;
`else
  localparam logic [7:0] DROP_ONE = 8'h00;
  localparam logic [7:0] DROP_SAT = 8'h00;
`endif

  // clock / reset
  logic c_clk   = 1'b0;
  logic reset_n = 1'b0;
  always #5 c_clk = ~c_clk;

  calc2_req_sched_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  calc2_req_sched #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .c_clk  (c_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [3:0]        cmd [4];
  logic [DATA_W-1:0] dat [4];
  logic [TAG_W-1:0]  tg  [4];
  assign bus.req1_cmd_in  = cmd[0]; assign bus.req2_cmd_in  = cmd[1];
  assign bus.req3_cmd_in  = cmd[2]; assign bus.req4_cmd_in  = cmd[3];
  assign bus.req1_data_in = dat[0]; assign bus.req2_data_in = dat[1];
  assign bus.req3_data_in = dat[2]; assign bus.req4_data_in = dat[3];
  assign bus.req1_tag_in  = tg[0];  assign bus.req2_tag_in  = tg[1];
  assign bus.req3_tag_in  = tg[2];  assign bus.req4_tag_in  = tg[3];

  logic [3:0]    busy;
  logic [OB-1:0] outb [4];
  logic [AB-1:0] alub;
  assign busy    = {bus.req4_busy, bus.req3_busy, bus.req2_busy, bus.req1_busy};
  assign outb[0] = {bus.out_resp1, bus.out_data1, bus.out_tag1};
  assign outb[1] = {bus.out_resp2, bus.out_data2, bus.out_tag2};
  assign outb[2] = {bus.out_resp3, bus.out_data3, bus.out_tag3};
  assign outb[3] = {bus.out_resp4, bus.out_data4, bus.out_tag4};
  assign alub    = {bus.alu_valid, bus.alu_cmd, bus.alu_op1, bus.alu_op2, bus.alu_port, bus.alu_tag};

  int n_cmp = 0;
  int n_err = 0;
  int bad_issue = 0;
  logic [1:0] exp_q[$];

  always @(negedge c_clk)
    if (reset_n && bus.alu_valid &&
        !(bus.alu_cmd inside {4'd1, 4'd2, 4'd5, 4'd6})) bad_issue++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(negedge c_clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      cmd[i] = '0;
      dat[i] = '0;
      tg[i]  = '0;
    end
    bus.alu_ready     = 1'b1;
    bus.alu_rsp_valid = 1'b0;
    bus.alu_rsp_resp  = '0;
    bus.alu_rsp_data  = '0;
    bus.alu_rsp_port  = '0;
    bus.alu_rsp_tag   = '0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Ports in mask start cmd c together: op1 = b1+i, op2 = b2+i, tag = i. Ends at t+2.
  task automatic start_ports(input logic [3:0] mask, input logic [3:0] c,
                             input logic [31:0] b1, input logic [31:0] b2);
    tick();
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin cmd[i] = c; dat[i] = b1 + 32'(i); tg[i] = 2'(i); end
    tick();
    for (int i = 0; i < 4; i++) begin
      cmd[i] = '0;
      if (mask[i]) dat[i] = b2 + 32'(i);
    end
    tick();
    for (int i = 0; i < 4; i++) dat[i] = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_dut();
    n_cmp++; if (busy !== 4'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0000", busy); end
    n_cmp++; if (alub !== '0) begin n_err++; $display("FAIL reset_alu: got %h want 0", alub); end
    n_cmp++; if (bus.drop_cnt !== 8'h00) begin n_err++; $display("FAIL reset_drop: got %h want 00", bus.drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (outb[i] !== '0) begin n_err++; $display("FAIL reset_out%0d: got %h want 0", i + 1, outb[i]); end
    end
  endtask

  task automatic test_add();
    tick(); cmd[0] = 4'd1; dat[0] = 32'h56; tg[0] = 2'd2;
    tick(); cmd[0] = 4'd0; dat[0] = 32'h103;
    n_cmp++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL add_busy_t1: got %b want 1", busy[0]); end
    tick(); dat[0] = '0;
    n_cmp++; if (bus.alu_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_t2: got %b want 0", bus.alu_valid); end
    tick();
    n_cmp++;
    if (alub !== {1'b1, 4'd1, 32'h56, 32'h103, 2'd0, 2'd2}) begin
      n_err++; $display("FAIL add_issue_t3: got %h want valid cmd1 56/103 port0 tag2", alub);
    end
    bus.alu_rsp_valid = 1'b1; bus.alu_rsp_resp = 2'b01; bus.alu_rsp_data = 32'h159;
    bus.alu_rsp_port  = 2'd0; bus.alu_rsp_tag  = 2'd2;
    tick(); bus.alu_rsp_valid = 1'b0;
    n_cmp++; if (outb[0] !== {2'b01, 32'h159, 2'd2}) begin n_err++; $display("FAIL add_resp: got %h want 1/159/2", outb[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL add_busy_free: got %b want 0", busy[0]); end
    n_cmp++; if (bus.alu_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_after: got %b want 0", bus.alu_valid); end
    tick();
    n_cmp++; if (bus.out_resp1 !== 2'b00) begin n_err++; $display("FAIL add_resp_pulse: got %b want 00", bus.out_resp1); end
  endtask

  task automatic check_grants(input string name);
    logic [1:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++;
      if ({bus.alu_valid, bus.alu_port, bus.alu_op1, bus.alu_op2, bus.alu_tag} !==
          {1'b1, e, 32'h10 + 32'(e), 32'h20 + 32'(e), e}) begin
        n_err++;
        $display("FAIL %s: got valid %b port %0d op1 %h want port %0d op1 %h",
                 name, bus.alu_valid, bus.alu_port, bus.alu_op1, e, 32'h10 + 32'(e));
      end
    end
    tick();
    n_cmp++; if (bus.alu_valid !== 1'b0) begin n_err++; $display("FAIL %s_idle: got %b want 0", name, bus.alu_valid); end
  endtask

  task automatic test_fairness();
    reset_dut();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    start_ports(4'b1111, 4'd1, 32'h10, 32'h20);
    check_grants("rr_all4");
    exp_q.push_back(2'd0); exp_q.push_back(2'd2);
    start_ports(4'b0101, 4'd2, 32'h10, 32'h20);
    check_grants("rr_1_3");
  endtask

  task automatic test_stall();
    bus.alu_ready = 1'b0;
    tick(); cmd[1] = 4'd2; dat[1] = 32'h158; tg[1] = 2'd1;
    tick(); cmd[1] = 4'd0; dat[1] = 32'h12;
    tick(); dat[1] = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 5) bus.alu_ready = 1'b1;
      n_cmp++;
      if ({alub, busy[1]} !== {1'b1, 4'd2, 32'h158, 32'h12, 2'd1, 2'd1, 1'b1}) begin
        n_err++; $display("FAIL stall_hold_c%0d: got %h busy %b want cmd2 158/12 port1 busy 1", k, alub, busy[1]);
      end
    end
    tick();
    n_cmp++; if ({bus.alu_valid, busy[1]} !== 2'b00) begin n_err++; $display("FAIL stall_release: got valid/busy %b%b want 00", bus.alu_valid, busy[1]); end
  endtask

  task automatic test_drop();
    int seen;
    seen = 0;
    bus.alu_ready = 1'b0;
    tick(); cmd[2] = 4'd1; dat[2] = 32'h11; tg[2] = 2'd3;
    tick(); cmd[2] = 4'd0; dat[2] = 32'h22;
    tick(); cmd[2] = 4'd6; dat[2] = 32'h99; tg[2] = 2'd0;
    tick(); cmd[2] = 4'd0; dat[2] = '0;
    n_cmp++; if (bus.drop_cnt !== DROP_ONE) begin n_err++; $display("FAIL drop_one: got %h want %h", bus.drop_cnt, DROP_ONE); end
    n_cmp++; if (alub !== {1'b1, 4'd1, 32'h11, 32'h22, 2'd2, 2'd3}) begin n_err++; $display("FAIL drop_issue: got %h want cmd1 11/22 port2 tag3", alub); end
    cmd[2] = 4'd9;
    repeat (300) begin
      tick();
      if (bus.out_resp3 !== 2'b00) seen++;
    end
    cmd[2] = 4'd0;
    tick();
    n_cmp++; if (bus.drop_cnt !== DROP_SAT) begin n_err++; $display("FAIL drop_sat: got %h want %h", bus.drop_cnt, DROP_SAT); end
    n_cmp++; if (alub !== {1'b1, 4'd1, 32'h11, 32'h22, 2'd2, 2'd3}) begin n_err++; $display("FAIL drop_issue_hold: got %h want first cmd", alub); end
    bus.alu_ready = 1'b1;
    tick();
    tick();
    if (bus.out_resp3 !== 2'b00) seen++;
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL drop_no_resp: got %0d resp cycles want 0", seen); end
    n_cmp++; if ({bus.alu_valid, busy[2]} !== 2'b00) begin n_err++; $display("FAIL drop_free: got %b%b want 00", bus.alu_valid, busy[2]); end
  endtask

  task automatic test_invalid();
    tick(); cmd[0] = 4'd7; dat[0] = 32'h5; tg[0] = 2'd1;
    tick(); cmd[0] = 4'd0; dat[0] = 32'h6;
    tick(); dat[0] = '0;
    tick();
    n_cmp++; if (outb[0] !== {2'b10, 32'h0, 2'd1}) begin n_err++; $display("FAIL inv_resp: got %h want 2/0/1", outb[0]); end
    n_cmp++; if ({busy[0], bus.alu_valid} !== 2'b10) begin n_err++; $display("FAIL inv_busy_t3: got %b want busy1 valid0", {busy[0], bus.alu_valid}); end
    tick();
    n_cmp++; if ({bus.out_resp1, busy[0]} !== 3'b000) begin n_err++; $display("FAIL inv_done_t4: got %b want 000", {bus.out_resp1, busy[0]}); end
  endtask

  task automatic test_collision();
    tick(); cmd[3] = 4'd3; dat[3] = 32'h77; tg[3] = 2'd3;
    tick(); cmd[3] = 4'd0; dat[3] = 32'h88;
    tick(); dat[3] = '0;
    bus.alu_rsp_valid = 1'b1; bus.alu_rsp_resp = 2'b01; bus.alu_rsp_data = 32'hABC;
    bus.alu_rsp_port  = 2'd3; bus.alu_rsp_tag  = 2'd1;
    tick(); bus.alu_rsp_valid = 1'b0;
    n_cmp++; if (outb[3] !== {2'b01, 32'hABC, 2'd1}) begin n_err++; $display("FAIL coll_alu_first: got %h want 1/abc/1", outb[3]); end
    n_cmp++; if (busy[3] !== 1'b1) begin n_err++; $display("FAIL coll_busy_t3: got %b want 1", busy[3]); end
    tick();
    n_cmp++; if (outb[3] !== {2'b10, 32'h0, 2'd3}) begin n_err++; $display("FAIL coll_local: got %h want 2/0/3", outb[3]); end
    n_cmp++; if (busy[3] !== 1'b1) begin n_err++; $display("FAIL coll_busy_t4: got %b want 1", busy[3]); end
    tick();
    n_cmp++; if ({bus.out_resp4, busy[3]} !== 3'b000) begin n_err++; $display("FAIL coll_done: got %b want 000", {bus.out_resp4, busy[3]}); end
    n_cmp++; if (bad_issue !== 0) begin n_err++; $display("FAIL no_invalid_issue: got %0d want 0", bad_issue); end
  endtask

  task automatic test_reset_mid();
    bus.alu_ready = 1'b0;
    tick(); cmd[0] = 4'd5; dat[0] = 32'h3; tg[0] = 2'd2;
    tick(); cmd[0] = 4'd0; dat[0] = 32'h4;
    tick(); dat[0] = '0;
    tick();
    n_cmp++; if (alub !== {1'b1, 4'd5, 32'h3, 32'h4, 2'd0, 2'd2}) begin n_err++; $display("FAIL rst_pre_issue: got %h want shl 3/4 port0", alub); end
    tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({alub, busy, bus.drop_cnt} !== '0) begin n_err++; $display("FAIL rst_async: got alu %h busy %b drop %h want 0", alub, busy, bus.drop_cnt); end
    n_cmp++; if ({outb[0], outb[1], outb[2], outb[3]} !== '0) begin n_err++; $display("FAIL rst_async_out: got nonzero want 0"); end
    tick();
    reset_n = 1'b1;
    bus.alu_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    start_ports(4'b0011, 4'd1, 32'h10, 32'h20);
    check_grants("rst_ptr");
  endtask

  initial begin
    test_reset();
    test_add();
    test_fairness();
    test_stall();
    test_drop();
    test_invalid();
    test_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/calc2_req_sched.md
# calc2_req_sched

Request scheduler between the four calc2 requester ports and one shared ALU issue port. Each port delivers two-cycle calc2 commands (command + operand 1, then operand 2). The scheduler collects each command into a one-entry per-port buffer and grants the ALU round-robin over a valid/ready handshake. It routes each ALU result back to the issuing port's out_resp/out_data/out_tag as a one-cycle pulse.

## Interface
- DATA_W, 32, operand/result width
- TAG_W, 2, requester tag width
- c_clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- reqN_cmd_in (N=1..4)  in  4  command; nonzero marks first beat
- reqN_data_in  in  DATA_W  operand 1 on first beat, operand 2 on the next cycle
- reqN_tag_in  in  TAG_W  tag, sampled on first beat
- reqN_busy  out  1  port buffer occupied or capturing
- out_respN  out  2  00 none, 01 success, 10 error/overflow
- out_dataN  out  DATA_W  result, valid when out_respN != 00
- out_tagN  out  TAG_W  tag of the answered command
- alu_valid / alu_ready  out / in  1  issue handshake
- alu_cmd  out  4; alu_op1, alu_op2  out  DATA_W; alu_port  out  2 (0..3); alu_tag  out  TAG_W
- alu_rsp_valid  in  1; alu_rsp_resp  in  2; alu_rsp_data  in  DATA_W; alu_rsp_port  in  2; alu_rsp_tag  in  TAG_W
- drop_cnt  out  8  dropped-command count (see Configuration)

## Operation
- Per-port FSM: IDLE -> OP2 -> FULL -> IDLE.
  - IDLE: a nonzero cmd with reqN_busy low latches cmd, op1 and tag, then moves to OP2.
  - OP2: latches op2 unconditionally; cmd is ignored. Moves to FULL.
  - FULL: leaves when the buffer is issued or locally answered.
- A nonzero cmd arriving while reqN_busy is high is dropped. No response is generated and drop_cnt increments.
- Valid cmds are 1 (add), 2 (sub), 5 (shl) and 6 (shr).
  - Any other nonzero cmd is never issued to the ALU.
  - It is answered locally with resp 10, data 0 and its own tag.
- Arbiter: round-robin over FULL buffers holding valid cmds.
  - After reset the pointer favours port 1.
  - After a grant to port k, search starts at k+1 and wraps 4 -> 1.
- Issue register: alu_* are registered.
  - They are held stable while alu_valid && !alu_ready.
  - No new grant is made until the handshake completes.
  - The granted buffer frees on the handshake cycle.
- Response routing: when alu_rsp_valid, the fields are registered onto the out_* set selected by alu_rsp_port.
  - alu_rsp_resp, data and tag pass unchanged.
- Collision: an ALU response and a local invalid-cmd response for the same port in the same cycle.
  - The ALU response wins.
  - The local response is deferred and its buffer stays FULL.
- Reset values: all out_respN/out_dataN/out_tagN = 0, reqN_busy = 0, alu_* = 0, drop_cnt = 0.
  - All port FSMs return to IDLE and the pointer returns to port 1.
  - Applies immediately on reset_n low, including mid-handshake.

## Timing
- First beat in cycle t:
  - reqN_busy goes high at t+1.
  - The buffer is FULL and eligible at t+2.
  - Earliest alu_valid is t+3.
- Handshake in cycle h: reqN_busy goes low at h+1, and the port may start a new command at h+1.
- Earliest back-to-back issues to the ALU are one per cycle while alu_ready is high.
- ALU response in cycle r: out_respN is nonzero in cycle r+1 only, then returns to 00.
- Local invalid response: out_respN is nonzero at t+3 at the earliest, for one cycle; reqN_busy goes low the following cycle.
- There is no ordering guarantee between ports. Per port, at most one command is outstanding in the buffer.

## Configuration
- CALC2_SCHED_DROPCNT_EN defined:
  - drop_cnt is an 8-bit counter of dropped commands across all ports.
  - It saturates at 0xFF.
  - Multiple drops in one cycle add their count, saturating.
- Not defined: drop_cnt is tied to 0 and no counter logic is built. Dropping behaviour is otherwise identical.

## Test plan
- Add: port 1 sends cmd 1, op 0x56, 0x103, tag 2.
  - Expect alu_cmd=1, op1=0x56, op2=0x103, port=0, tag=2 at t+3.
  - The model returns 0x159/01 -> out_resp1=01, out_data1=0x159, out_tag1=2 for exactly one cycle.
- Fairness: all four ports start simultaneously with alu_ready high.
  - Expect grants in order ports 1, 2, 3, 4 on consecutive cycles.
  - Then only ports 1 and 3 re-request -> grant order 1, 3.
- Stall: alu_ready low for 5 cycles with port 2 (cmd 2, 0x158, 0x12) issued.
  - alu_* stay stable and req2_busy stays high throughout.
  - The handshake completes on the 6th cycle and req2_busy falls the next cycle.
- Drop: port 3 sends a second command while busy.
  - No ALU issue and no response for it.
  - drop_cnt=1 with CALC2_SCHED_DROPCNT_EN, 0 without.
  - 300 drops saturate the counter at 0xFF.
- Invalid cmd 3 on port 4, colliding with an ALU response to port 4 in the same cycle.
  - The ALU result appears first.
  - out_resp4=10, out_data4=0 with the original tag appears the next cycle.
  - The ALU never sees cmd 3.
- Reset_n pulsed low during a stalled handshake: all outputs read 0 immediately, and after release the pointer favours port 1.
